// File: rtl/host_mem_loader_pkg.sv
// Shared accelerator definitions: loader FSM encoding, scratchpad bank indices
// and the bank-select width helper used by the host memory loader.
package host_mem_loader_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } loader_state_t;

    localparam int BANK_WEIGHT   = 0;
    localparam int BANK_ACT      = 1;
    localparam int BANK_OUT      = 2;
    localparam int BLOCKED_CNT_W = 16;

    // A bank select is always at least one bit wide, even for a single bank.
    function automatic int bank_width(input int num_banks);
        if (num_banks <= 2) begin
            return 1;
        end
        return $clog2(num_banks);
    endfunction

endpackage

// File: rtl/host_mem_loader_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/host_mem_loader.sv
// Host access port onto the accelerator scratchpad banks: arbitrates against the
// accelerator via acc_idle, issues one-hot bank strobes and returns read data.
module host_mem_loader
    import host_mem_loader_pkg::*;
#(
    parameter int  DATA_W    = 32,
    parameter int  ADDR_W    = 10,
    parameter int  NUM_BANKS = 3,
    localparam int BANK_W    = bank_width(NUM_BANKS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          acc_idle,
    input  logic                          host_valid,
    output logic                          host_ready,
    input  logic                          host_we,
    input  logic                          host_burst,
    input  logic [BANK_W-1:0]             host_bank,
    input  logic [ADDR_W-1:0]             host_addr,
    input  logic [DATA_W-1:0]             host_wdata,
    output logic                          host_rvalid,
    output logic [DATA_W-1:0]             host_rdata,
    output logic [NUM_BANKS-1:0]          bank_we,
    output logic [NUM_BANKS-1:0]          bank_re,
    output logic [ADDR_W-1:0]             bank_addr,
    output logic [DATA_W-1:0]             bank_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0]   bank_rdata,
    output logic [BLOCKED_CNT_W-1:0]      blocked_cnt
);

    loader_state_t          state_reg;
    logic [ADDR_W-1:0]      ptr_reg;
    logic [NUM_BANKS-1:0]   rd_sel_reg;

    logic                   accept;
    logic [ADDR_W-1:0]      req_addr;
    logic [NUM_BANKS-1:0]   bank_sel;
    logic [DATA_W-1:0]      rd_slice [NUM_BANKS];
    logic [DATA_W-1:0]      rd_data_next;

    assign host_ready = acc_idle & (state_reg == IDLE);
    assign accept     = host_valid & host_ready;
    assign req_addr   = host_burst ? ptr_reg : host_addr;

    // An out-of-range bank decodes to an all-zero select: accepted, but no strobe.
    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            assign bank_sel[gi] = (host_bank == BANK_W'(gi));
            assign rd_slice[gi] = bank_rdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        rd_data_next = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (rd_sel_reg[i]) begin
                rd_data_next = rd_data_next | rd_slice[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            rd_sel_reg  <= '0;
            bank_we     <= '0;
            bank_re     <= '0;
            bank_addr   <= '0;
            bank_wdata  <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            bank_we     <= '0;
            bank_re     <= '0;
            host_rvalid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        bank_addr <= req_addr;
                        ptr_reg   <= req_addr + ADDR_W'(1);
                        if (host_we) begin
                            bank_we    <= bank_sel;
                            bank_wdata <= host_wdata;
                        end else begin
                            bank_re    <= bank_sel;
                            rd_sel_reg <= bank_sel;
                            state_reg  <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    // Completes regardless of acc_idle; an empty select yields zero data.
                    host_rdata  <= rd_data_next;
                    host_rvalid <= 1'b1;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    sat_counter #(
        .WIDTH (BLOCKED_CNT_W)
    ) u_blocked_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (host_valid & ~acc_idle),
        .count (blocked_cnt)
    );

endmodule

// File: tb/tb_host_mem_loader.sv
// Randomized scoreboard bench for host_mem_loader with a simple SRAM bank model.
module tb_host_mem_loader;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NB = 3;
    localparam int DEPTH = 1 << AW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           acc_idle = 1'b0;
    logic           host_valid = 1'b0;
    logic           host_ready;
    logic           host_we = 1'b0;
    logic           host_burst = 1'b0;
    logic [1:0]     host_bank = '0;
    logic [AW-1:0]  host_addr = '0;
    logic [DW-1:0]  host_wdata = '0;
    logic           host_rvalid;
    logic [DW-1:0]  host_rdata;
    logic [NB-1:0]  bank_we;
    logic [NB-1:0]  bank_re;
    logic [AW-1:0]  bank_addr;
    logic [DW-1:0]  bank_wdata;
    logic [NB*DW-1:0] bank_rdata;
    logic [15:0]    blocked_cnt;

    host_mem_loader #(.DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .acc_idle    (acc_idle),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_we     (host_we),
        .host_burst  (host_burst),
        .host_bank   (host_bank),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .bank_we     (bank_we),
        .bank_re     (bank_re),
        .bank_addr   (bank_addr),
        .bank_wdata  (bank_wdata),
        .bank_rdata  (bank_rdata),
        .blocked_cnt (blocked_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [2:0]  strobe;
        logic [9:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];
    exp_t dq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int busy_cyc = -1;
    int ptr     = 0;
    logic [15:0] exp_blk = '0;

    logic [31:0] sram    [NB][DEPTH];
    logic [31:0] ref_mem [NB][DEPTH];

    always @(posedge clk) cyc++;

    // SRAM banks: written by the DUT strobes, read data follows bank_addr.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_we[b]) sram[b][bank_addr] <= bank_wdata;
        end
    end
    assign bank_rdata = {sram[2][bank_addr], sram[1][bank_addr], sram[0][bank_addr]};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_req(input bit we, input bit burst, input int bank, input int addr,
                          input logic [31:0] wd, input bit idle);
        int  a;
        bit  exp_ready;
        @(negedge clk);
        acc_idle   = idle;
        host_valid = 1'b1;
        host_we    = we;
        host_burst = burst;
        host_bank  = 2'(bank);
        host_addr  = AW'(addr);
        host_wdata = wd;
        #3;
        exp_ready = idle && (cyc != busy_cyc);
        check("host_ready", 64'(host_ready), 64'(exp_ready));
        if (exp_ready) begin
            a   = burst ? ptr : addr;
            ptr = (a + 1) % DEPTH;
            if (we) begin
                if (bank < NB) begin
                    ref_mem[bank][a] = wd;
                    wq.push_back('{cyc + 1, 3'(1 << bank), 10'(a), wd});
                end
            end else begin
                if (bank < NB) rq.push_back('{cyc + 1, 3'(1 << bank), 10'(a), 32'h0});
                dq.push_back('{cyc + 2, 3'b0, 10'h0, (bank < NB) ? ref_mem[bank][a] : 32'h0});
                busy_cyc = cyc + 1;
            end
            $display("[TB] cyc %0d accept %s bank %0d addr %0d data %h", cyc, we ? "WR" : "RD", bank, a, wd);
        end else begin
            $display("[TB] cyc %0d request held off (idle=%0d)", cyc, idle);
        end
    endtask

    task automatic idle_cycle(input bit idle);
        @(negedge clk);
        host_valid = 1'b0;
        acc_idle   = idle;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or read data.
    exp_t e;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            exp_blk = '0;
        end else begin
            if (host_valid && !acc_idle && exp_blk != 16'hFFFF) exp_blk++;
            check("blocked_cnt", 64'(blocked_cnt), 64'(exp_blk));
            if (|bank_we || |bank_re) check("we_re_exclusive", 64'(|bank_we && |bank_re), 64'd0);
            if (bank_we != 0 || (wq.size() > 0 && wq[0].cyc <= cyc)) begin
                if (wq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL bank_we_unexpected: got %b expected 000 (cycle %0d)", bank_we, cyc);
                end else begin
                    e = wq.pop_front();
                    check("wr_cycle", 64'(cyc), 64'(e.cyc));
                    check("wr_strobe_addr_data", {19'b0, bank_we, bank_addr, bank_wdata},
                          {19'b0, e.strobe, e.addr, e.data});
                end
            end
            if (bank_re != 0 || (rq.size() > 0 && rq[0].cyc <= cyc)) begin
                if (rq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL bank_re_unexpected: got %b expected 000 (cycle %0d)", bank_re, cyc);
                end else begin
                    e = rq.pop_front();
                    check("rd_cycle", 64'(cyc), 64'(e.cyc));
                    check("rd_strobe_addr", {51'b0, bank_re, bank_addr}, {51'b0, e.strobe, e.addr});
                end
            end
            if (host_rvalid || (dq.size() > 0 && dq[0].cyc <= cyc)) begin
                if (dq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rvalid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = dq.pop_front();
                    check("rvalid_cycle", 64'(cyc), 64'(e.cyc));
                    check("rdata", {31'b0, host_rvalid, host_rdata}, {31'b0, 1'b1, e.data});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int b = 0; b < NB; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                sram[b][a]    = $urandom;
                ref_mem[b][a] = sram[b][a];
            end
        end
        sram[2][5]    = 32'hDEADBEEF;
        ref_mem[2][5] = 32'hDEADBEEF;

        // Reset values
        #2;
        check("reset_strobes", 64'({bank_we, bank_re}), 64'd0);
        check("reset_addr_wdata", 64'({bank_addr, bank_wdata}), 64'd0);
        check("reset_rdata_cnt", 64'({host_rvalid, host_rdata, blocked_cnt}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Host blocked for five cycles
        for (int i = 0; i < 5; i++) do_req(1'b1, 1'b0, 0, 3, 32'h11111111, 1'b0);
        idle_cycle(1'b1);
        check("blocked_cnt_5", 64'(blocked_cnt), 64'd5);

        // Single write to weight bank
        do_req(1'b1, 1'b0, 0, 0, 32'h02020202, 1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // Pointer wrap across the top of the address space
        do_req(1'b1, 1'b0, 1, 1021, $urandom, 1'b1);
        for (int i = 0; i < 3; i++) do_req(1'b1, 1'b1, 1, 0, $urandom, 1'b1);
        idle_cycle(1'b1);

        // Read output bank, then a request that must be held off one cycle
        do_req(1'b0, 1'b0, 2, 5, 32'h0, 1'b1);
        do_req(1'b1, 1'b0, 0, 9, 32'h5A5A5A5A, 1'b1);
        idle_cycle(1'b1);

        // Read of a nonexistent bank
        do_req(1'b0, 1'b0, 3, 8, 32'h0, 1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // acc_idle drops while a read is in flight
        do_req(1'b0, 1'b1, 0, 0, 32'h0, 1'b1);
        idle_cycle(1'b0);
        idle_cycle(1'b1);

        // Reset asserted during RD_WAIT
        do_req(1'b0, 1'b0, 0, 7, 32'h0, 1'b1);
        @(negedge clk);
        host_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midread_rst_strobes", 64'({bank_we, bank_re}), 64'd0);
        check("midread_rst_addr_wdata", 64'({bank_addr, bank_wdata}), 64'd0);
        check("midread_rst_rdata_cnt", 64'({host_rvalid, host_rdata, blocked_cnt}), 64'd0);
        wq.delete(); rq.delete(); dq.delete();
        ptr = 0;
        busy_cyc = -1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) idle_cycle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                idle_cycle($urandom_range(0, 1) == 1);
            end else begin
                do_req($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 3), $urandom_range(0, DEPTH - 1),
                       $urandom, $urandom_range(0, 4) != 0);
            end
        end

        for (int i = 0; i < 4; i++) idle_cycle(1'b1);
        for (int i = 0; i < 20 && (wq.size() + rq.size() + dq.size()) > 0; i++) @(posedge clk);
        check("scoreboard_drained", 64'(wq.size() + rq.size() + dq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
